// File: rtl/obi_mem_arbiter.sv
// Two-master (instr/data) to one-slave OBI arbiter with round-robin selection,
// address-phase hold until grant, and an ID queue routing responses back.
module obi_mem_arbiter #(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic              clk_i,
  input  logic              reset,
  input  logic              instr_req_i,
  input  logic [31:0]       instr_addr_i,
  output logic              instr_gnt_o,
  output logic              instr_rvalid_o,
  output logic [31:0]       instr_rdata_o,
  input  logic              data_req_i,
  input  logic              data_we_i,
  input  logic [3:0]        data_be_i,
  input  logic [31:0]       data_addr_i,
  input  logic [31:0]       data_wdata_i,
  output logic              data_gnt_o,
  output logic              data_rvalid_o,
  output logic [31:0]       data_rdata_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [3:0]        mem_be_o,
  output logic [31:0]       mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [31:0]       mem_rdata_i,
  output logic [CNT_W-1:0]  outstanding_o,
  output logic              protocol_err_o
);

  localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTSTANDING);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);

  typedef enum logic {ST_IDLE, ST_HOLD} state_e;
  typedef enum logic {SEL_INSTR = 1'b0, SEL_DATA = 1'b1} sel_e;

  state_e           state;
  sel_e             lock_sel;
  sel_e             last_sel;
  sel_e             sel;
  sel_e             head;
  sel_e             id_q [MAX_OUTSTANDING];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             err_q;
  logic             full;
  logic             empty;
  logic             sel_req;
  logic             req_int;
  logic             handshake;
  logic             pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  // Master selection: locked while holding, otherwise round-robin on ties
  always_comb begin
    sel = SEL_INSTR;
    if (state == ST_HOLD) begin
      sel = lock_sel;
    end else if (instr_req_i && data_req_i) begin
      sel = (last_sel == SEL_INSTR) ? SEL_DATA : SEL_INSTR;
    end else if (data_req_i) begin
      sel = SEL_DATA;
    end
  end

  assign full      = (count == CNT_MAX);
  assign empty     = (count == '0);
  assign sel_req   = (sel == SEL_DATA) ? data_req_i : instr_req_i;
  assign req_int   = sel_req && !full;
  assign handshake = req_int && mem_gnt_i;
  // Pop only against the pre-push occupancy so a same-cycle push cannot be answered
  assign pop       = mem_rvalid_i && !empty;
  assign head      = id_q[rd_ptr];

  // Address phase, grants and response routing; everything forced low in reset
  always_comb begin
    mem_req_o      = 1'b0;
    mem_we_o       = 1'b0;
    mem_be_o       = 4'h0;
    mem_addr_o     = '0;
    mem_wdata_o    = '0;
    instr_gnt_o    = 1'b0;
    data_gnt_o     = 1'b0;
    instr_rvalid_o = 1'b0;
    data_rvalid_o  = 1'b0;
    instr_rdata_o  = '0;
    data_rdata_o   = '0;
    if (!reset) begin
      mem_req_o      = req_int;
      mem_we_o       = (sel == SEL_DATA) ? data_we_i : 1'b0;
      mem_be_o       = (sel == SEL_DATA) ? data_be_i : 4'hF;
      mem_addr_o     = (sel == SEL_DATA) ? data_addr_i : instr_addr_i;
      mem_wdata_o    = (sel == SEL_DATA) ? data_wdata_i : 32'h0;
      instr_gnt_o    = handshake && (sel == SEL_INSTR);
      data_gnt_o     = handshake && (sel == SEL_DATA);
      instr_rvalid_o = pop && (head == SEL_INSTR);
      data_rvalid_o  = pop && (head == SEL_DATA);
      instr_rdata_o  = mem_rdata_i;
      data_rdata_o   = mem_rdata_i;
    end
  end

  assign outstanding_o  = count;
  assign protocol_err_o = err_q;

  // Hold FSM: latch the selection while the address phase waits for grant
  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      lock_sel <= SEL_INSTR;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_int && !mem_gnt_i) begin
            state    <= ST_HOLD;
            lock_sel <= sel;
          end
        end
        ST_HOLD: begin
          if (!full && (mem_gnt_i || !sel_req)) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // ID queue, occupancy counter, round-robin history and sticky error flag
  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(MAX_OUTSTANDING); i++) begin
        id_q[i] <= SEL_INSTR;
      end
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      last_sel <= SEL_INSTR;
      err_q    <= 1'b0;
    end else begin
      if (handshake) begin
        id_q[wr_ptr] <= sel;
        wr_ptr       <= ptr_inc(wr_ptr);
        last_sel     <= sel;
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({handshake, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (mem_rvalid_i && empty) begin
        err_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_obi_mem_arbiter.sv
// Directed self-checking bench for obi_mem_arbiter.
module tb_obi_mem_arbiter;

  logic        clk_i = 1'b0;
  logic        reset;
  logic        instr_req_i;
  logic [31:0] instr_addr_i;
  logic        instr_gnt_o;
  logic        instr_rvalid_o;
  logic [31:0] instr_rdata_o;
  logic        data_req_i;
  logic        data_we_i;
  logic [3:0]  data_be_i;
  logic [31:0] data_addr_i;
  logic [31:0] data_wdata_i;
  logic        data_gnt_o;
  logic        data_rvalid_o;
  logic [31:0] data_rdata_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic [1:0]  outstanding_o;
  logic        protocol_err_o;

  int checks = 0;
  int errors = 0;

  obi_mem_arbiter #(.MAX_OUTSTANDING(2)) dut (
    .clk_i(clk_i), .reset(reset),
    .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i), .instr_gnt_o(instr_gnt_o),
    .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o),
    .data_req_i(data_req_i), .data_we_i(data_we_i), .data_be_i(data_be_i),
    .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i), .data_gnt_o(data_gnt_o),
    .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .outstanding_o(outstanding_o), .protocol_err_o(protocol_err_o)
  );

  always #5 clk_i = ~clk_i;

  // Advance to 1 ns after the next rising edge
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_inputs();
    instr_req_i = 0; instr_addr_i = '0;
    data_req_i = 0; data_we_i = 0; data_be_i = '0; data_addr_i = '0; data_wdata_i = '0;
    mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = '0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1;
    instr_req_i = 1; mem_gnt_i = 1; mem_rvalid_i = 1; mem_rdata_i = 32'hA5A5A5A5;
    #3;
    checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL rst_mem_req: got %b exp 0", mem_req_o); end
    checks++; if (instr_gnt_o !== 1'b0) begin errors++; $display("FAIL rst_instr_gnt: got %b exp 0", instr_gnt_o); end
    checks++; if (instr_rvalid_o !== 1'b0) begin errors++; $display("FAIL rst_instr_rvalid: got %b exp 0", instr_rvalid_o); end
    checks++; if (instr_rdata_o !== 32'h0) begin errors++; $display("FAIL rst_rdata: got %h exp 0", instr_rdata_o); end
    checks++; if (outstanding_o !== 2'd0) begin errors++; $display("FAIL rst_outstanding: got %0d exp 0", outstanding_o); end
    checks++; if (protocol_err_o !== 1'b0) begin errors++; $display("FAIL rst_err: got %b exp 0", protocol_err_o); end
    tick(); tick();
    clear_inputs();
    reset = 0;
    tick();
  endtask

  task automatic test_single_read();
    instr_req_i = 1; instr_addr_i = 32'h1A000080;
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++; if (mem_req_o !== 1'b1) begin errors++; $display("FAIL sr_req_wait%0d: got %b exp 1", c, mem_req_o); end
      checks++; if (mem_addr_o !== 32'h1A000080) begin errors++; $display("FAIL sr_addr_wait%0d: got %h exp 1a000080", c, mem_addr_o); end
      checks++; if (instr_gnt_o !== 1'b0) begin errors++; $display("FAIL sr_gnt_early%0d: got %b exp 0", c, instr_gnt_o); end
      tick();
    end
    mem_gnt_i = 1;
    #1;
    checks++; if (instr_gnt_o !== 1'b1) begin errors++; $display("FAIL sr_gnt: got %b exp 1", instr_gnt_o); end
    checks++; if (data_gnt_o !== 1'b0) begin errors++; $display("FAIL sr_data_gnt: got %b exp 0", data_gnt_o); end
    checks++; if ({mem_we_o, mem_be_o} !== 5'b0_1111) begin errors++; $display("FAIL sr_we_be: got %b exp 01111", {mem_we_o, mem_be_o}); end
    tick();
    instr_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h00000013;
    #1;
    checks++; if (instr_gnt_o !== 1'b0) begin errors++; $display("FAIL sr_gnt_once: got %b exp 0", instr_gnt_o); end
    checks++; if (instr_rvalid_o !== 1'b1) begin errors++; $display("FAIL sr_rvalid: got %b exp 1", instr_rvalid_o); end
    checks++; if (instr_rdata_o !== 32'h13) begin errors++; $display("FAIL sr_rdata: got %h exp 13", instr_rdata_o); end
    checks++; if (data_rvalid_o !== 1'b0) begin errors++; $display("FAIL sr_data_rvalid: got %b exp 0", data_rvalid_o); end
    checks++; if (outstanding_o !== 2'd1) begin errors++; $display("FAIL sr_out1: got %0d exp 1", outstanding_o); end
    tick();
    clear_inputs();
    #1;
    checks++; if (outstanding_o !== 2'd0) begin errors++; $display("FAIL sr_out0: got %0d exp 0", outstanding_o); end
    tick();
  endtask

  // Grants alternate data/instr; full blocks grants; push+pop keeps count
  task automatic test_contention();
    logic [3:0] exp_gnt [6];  // {instr_gnt, data_gnt, instr_rvalid, data_rvalid}
    logic [1:0] exp_cnt [6];  // occupancy seen during the cycle
    logic [3:0] got;
    exp_gnt[0] = 4'b0100; exp_cnt[0] = 2'd0;
    exp_gnt[1] = 4'b1000; exp_cnt[1] = 2'd1;
    exp_gnt[2] = 4'b0001; exp_cnt[2] = 2'd2;
    exp_gnt[3] = 4'b0110; exp_cnt[3] = 2'd1;
    exp_gnt[4] = 4'b1000; exp_cnt[4] = 2'd1;
    exp_gnt[5] = 4'b0001; exp_cnt[5] = 2'd2;
    instr_addr_i = 32'h1A000200; data_addr_i = 32'h30000000; data_be_i = 4'h5;
    for (int c = 0; c < 6; c++) begin
      instr_req_i  = (c != 5);
      data_req_i   = (c != 5);
      mem_gnt_i    = 1;
      mem_rvalid_i = (c == 2 || c == 3 || c == 5);
      #1;
      got = {instr_gnt_o, data_gnt_o, instr_rvalid_o, data_rvalid_o};
      checks++; if (got !== exp_gnt[c]) begin errors++; $display("FAIL ct_hs%0d: got %b exp %b", c, got, exp_gnt[c]); end
      checks++; if (outstanding_o !== exp_cnt[c]) begin errors++; $display("FAIL ct_cnt%0d: got %0d exp %0d", c, outstanding_o, exp_cnt[c]); end
      if (c == 2) begin
        checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL ct_full_req: got %b exp 0", mem_req_o); end
      end
      if (c == 3) begin
        checks++; if (mem_addr_o !== 32'h30000000) begin errors++; $display("FAIL ct_addr_data: got %h exp 30000000", mem_addr_o); end
      end
      tick();
    end
    clear_inputs();
    mem_rvalid_i = 1;
    #1;
    checks++; if ({instr_rvalid_o, data_rvalid_o} !== 2'b10) begin errors++; $display("FAIL ct_drain: got %b exp 10", {instr_rvalid_o, data_rvalid_o}); end
    tick();
    clear_inputs();
    #1;
    checks++; if (outstanding_o !== 2'd0) begin errors++; $display("FAIL ct_empty: got %0d exp 0", outstanding_o); end
    checks++; if (protocol_err_o !== 1'b0) begin errors++; $display("FAIL ct_err: got %b exp 0", protocol_err_o); end
    tick();
  endtask

  // A held data address phase is not stolen by a later instr request
  task automatic test_hold();
    data_req_i = 1; data_addr_i = 32'h20000000; mem_gnt_i = 1;
    #1;
    checks++; if (data_gnt_o !== 1'b1) begin errors++; $display("FAIL hd_pre_gnt: got %b exp 1", data_gnt_o); end
    tick();
    clear_inputs();
    mem_rvalid_i = 1;
    #1;
    checks++; if (data_rvalid_o !== 1'b1) begin errors++; $display("FAIL hd_pre_rvalid: got %b exp 1", data_rvalid_o); end
    tick();
    clear_inputs();
    data_req_i = 1; data_we_i = 1; data_be_i = 4'h3;
    data_addr_i = 32'h20000010; data_wdata_i = 32'hDEADBEEF;
    instr_addr_i = 32'h1A000100;
    for (int c = 0; c < 3; c++) begin
      instr_req_i = (c > 0);
      #1;
      checks++; if (mem_addr_o !== 32'h20000010) begin errors++; $display("FAIL hd_addr%0d: got %h exp 20000010", c, mem_addr_o); end
      checks++; if ({mem_req_o, mem_we_o, mem_be_o} !== 6'b11_0011) begin errors++; $display("FAIL hd_ctrl%0d: got %b exp 110011", c, {mem_req_o, mem_we_o, mem_be_o}); end
      checks++; if ({instr_gnt_o, data_gnt_o} !== 2'b00) begin errors++; $display("FAIL hd_nogrant%0d: got %b exp 00", c, {instr_gnt_o, data_gnt_o}); end
      tick();
    end
    mem_gnt_i = 1;
    #1;
    checks++; if ({instr_gnt_o, data_gnt_o} !== 2'b01) begin errors++; $display("FAIL hd_gnt_data: got %b exp 01", {instr_gnt_o, data_gnt_o}); end
    checks++; if (mem_wdata_o !== 32'hDEADBEEF) begin errors++; $display("FAIL hd_wdata: got %h exp deadbeef", mem_wdata_o); end
    tick();
    data_req_i = 0;
    #1;
    checks++; if ({instr_gnt_o, data_gnt_o} !== 2'b10) begin errors++; $display("FAIL hd_gnt_instr: got %b exp 10", {instr_gnt_o, data_gnt_o}); end
    checks++; if (mem_addr_o !== 32'h1A000100) begin errors++; $display("FAIL hd_addr_instr: got %h exp 1a000100", mem_addr_o); end
    checks++; if ({mem_we_o, mem_be_o} !== 5'b0_1111) begin errors++; $display("FAIL hd_instr_we_be: got %b exp 01111", {mem_we_o, mem_be_o}); end
    tick();
    clear_inputs();
    mem_rvalid_i = 1;
    #1;
    checks++; if ({instr_rvalid_o, data_rvalid_o} !== 2'b01) begin errors++; $display("FAIL hd_resp0: got %b exp 01", {instr_rvalid_o, data_rvalid_o}); end
    tick();
    #1;
    checks++; if ({instr_rvalid_o, data_rvalid_o} !== 2'b10) begin errors++; $display("FAIL hd_resp1: got %b exp 10", {instr_rvalid_o, data_rvalid_o}); end
    tick();
    clear_inputs();
    #1;
    checks++; if (outstanding_o !== 2'd0) begin errors++; $display("FAIL hd_empty: got %0d exp 0", outstanding_o); end
    tick();
  endtask

  task automatic test_error_and_reset();
    mem_rvalid_i = 1; mem_rdata_i = 32'h77;
    #1;
    checks++; if ({instr_rvalid_o, data_rvalid_o} !== 2'b00) begin errors++; $display("FAIL er_no_rvalid: got %b exp 00", {instr_rvalid_o, data_rvalid_o}); end
    tick();
    clear_inputs();
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++; if (protocol_err_o !== 1'b1) begin errors++; $display("FAIL er_sticky%0d: got %b exp 1", c, protocol_err_o); end
      checks++; if (outstanding_o !== 2'd0) begin errors++; $display("FAIL er_cnt%0d: got %0d exp 0", c, outstanding_o); end
      tick();
    end
    instr_req_i = 1; instr_addr_i = 32'h1A000300; mem_gnt_i = 1;
    tick();
    #1;
    checks++; if (outstanding_o !== 2'd1) begin errors++; $display("FAIL er_pre_rst_cnt: got %0d exp 1", outstanding_o); end
    mem_rvalid_i = 1; mem_rdata_i = 32'h55;
    reset = 1;
    #1;
    checks++; if ({mem_req_o, instr_gnt_o, data_gnt_o, instr_rvalid_o, data_rvalid_o} !== 5'b0) begin errors++; $display("FAIL er_rst_ctrl: got %b exp 00000", {mem_req_o, instr_gnt_o, data_gnt_o, instr_rvalid_o, data_rvalid_o}); end
    checks++; if (mem_addr_o !== 32'h0) begin errors++; $display("FAIL er_rst_addr: got %h exp 0", mem_addr_o); end
    checks++; if (mem_be_o !== 4'h0) begin errors++; $display("FAIL er_rst_be: got %h exp 0", mem_be_o); end
    checks++; if (outstanding_o !== 2'd0) begin errors++; $display("FAIL er_rst_cnt: got %0d exp 0", outstanding_o); end
    checks++; if (protocol_err_o !== 1'b0) begin errors++; $display("FAIL er_rst_err: got %b exp 0", protocol_err_o); end
    tick();
    clear_inputs();
    reset = 0;
    mem_rvalid_i = 1; mem_rdata_i = 32'h99;
    #1;
    checks++; if ({instr_rvalid_o, data_rvalid_o} !== 2'b00) begin errors++; $display("FAIL er_late_rvalid: got %b exp 00", {instr_rvalid_o, data_rvalid_o}); end
    tick();
    clear_inputs();
    #1;
    checks++; if (protocol_err_o !== 1'b1) begin errors++; $display("FAIL er_late_err: got %b exp 1", protocol_err_o); end
    tick();
  endtask

  initial begin
    reset = 1;
    clear_inputs();
    test_reset();
    test_single_read();
    test_contention();
    test_hold();
    test_error_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
